// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcode map, jump kinds, ALU op codes and
// the decoded control payload carried from decode to execute.
package decode_pkg;

   localparam int unsigned ALU_W  = 4;
   localparam int unsigned JUMP_W = 2;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   localparam logic [JUMP_W-1:0] JUMP_NONE   = 2'd0;
   localparam logic [JUMP_W-1:0] JUMP_JAL    = 2'd1;
   localparam logic [JUMP_W-1:0] JUMP_JALR   = 2'd2;
   localparam logic [JUMP_W-1:0] JUMP_BRANCH = 2'd3;

   // {funct7[5], funct3} for register ops; branches reuse {1, funct3}
   localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0001;
   localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0010;
   localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0011;
   localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
   localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0101;
   localparam logic [ALU_W-1:0] ALU_OR   = 4'b0110;
   localparam logic [ALU_W-1:0] ALU_AND  = 4'b0111;
   localparam logic [ALU_W-1:0] ALU_SUB  = 4'b1000;
   localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1101;

   typedef struct packed {
      logic [4:0]        rd;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic              wb_en;
      logic              en_imm;
      logic              en_jump;
      logic [ALU_W-1:0]  alu_op;
      logic [JUMP_W-1:0] jump;
      logic              mem_rd;
      logic              mem_wr;
      logic [2:0]        mem_funct3;
      logic              illegal;
   } dec_ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I decoder: instruction and pc in, control fields,
// immediate and pc-relative address out, with strict illegal checking.
module decode_comb
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_pc,
   output dec_ctrl_t       o_ctrl_c,
   output logic [XLEN-1:0] o_imm_c,
   output logic [XLEN-1:0] o_jump_addr_c
);

   logic [6:0]      opcode;
   logic [6:0]      funct7;
   logic [2:0]      funct3;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] imm_shamt;
   logic [XLEN-1:0] pc_plus4;

   assign opcode = i_instr[6:0];
   assign rd     = i_instr[11:7];
   assign funct3 = i_instr[14:12];
   assign rs1    = i_instr[19:15];
   assign rs2    = i_instr[24:20];
   assign funct7 = i_instr[31:25];

   assign imm_i     = XLEN'($signed(i_instr[31:20]));
   assign imm_s     = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
   assign imm_b     = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
   assign imm_u     = XLEN'($signed({i_instr[31:12], 12'b0}));
   assign imm_j     = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
   assign imm_shamt = XLEN'(i_instr[24:20]);
   assign pc_plus4  = i_pc + XLEN'(4);

   // Each opcode class fills only the fields it uses; illegal encodings are
   // squashed to an all-zero control word with only the illegal flag set.
   always_comb begin
      logic writes;
      logic legal;
      o_ctrl_c      = '0;
      o_imm_c       = '0;
      o_jump_addr_c = '0;
      writes        = 1'b0;
      legal         = 1'b0;
      case (opcode)
         OPC_OP: begin
            legal = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            writes          = 1'b1;
            o_ctrl_c.rs1    = rs1;
            o_ctrl_c.rs2    = rs2;
            o_ctrl_c.alu_op = {funct7[5], funct3};
         end
         OPC_OP_IMM: begin
            writes          = 1'b1;
            o_ctrl_c.rs1    = rs1;
            o_ctrl_c.en_imm = 1'b1;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000 && funct3 == 3'b101);
               o_imm_c         = imm_shamt;
               o_ctrl_c.alu_op = {funct7[5], funct3};
            end else begin
               legal           = 1'b1;
               o_imm_c         = imm_i;
               o_ctrl_c.alu_op = {1'b0, funct3};
            end
         end
         OPC_LUI: begin
            legal           = 1'b1;
            writes          = 1'b1;
            o_ctrl_c.en_imm = 1'b1;
            o_imm_c         = imm_u;
         end
         OPC_AUIPC: begin
            legal            = 1'b1;
            writes           = 1'b1;
            o_ctrl_c.en_imm  = 1'b1;
            o_ctrl_c.en_jump = 1'b1;
            o_imm_c          = imm_u;
            o_jump_addr_c    = i_pc;
         end
         OPC_JAL: begin
            legal           = 1'b1;
            writes          = 1'b1;
            o_ctrl_c.en_imm = 1'b1;
            o_ctrl_c.jump   = JUMP_JAL;
            o_imm_c         = pc_plus4;
            o_jump_addr_c   = i_pc + imm_j;
         end
         OPC_JALR: begin
            legal           = (funct3 == 3'b000);
            writes          = 1'b1;
            o_ctrl_c.rs1    = rs1;
            o_ctrl_c.en_imm = 1'b1;
            o_ctrl_c.jump   = JUMP_JALR;
            o_imm_c         = imm_i;
            o_jump_addr_c   = pc_plus4;
         end
         OPC_BRANCH: begin
            legal           = (funct3 != 3'b010) && (funct3 != 3'b011);
            o_ctrl_c.rs1    = rs1;
            o_ctrl_c.rs2    = rs2;
            o_ctrl_c.jump   = JUMP_BRANCH;
            o_ctrl_c.alu_op = {1'b1, funct3};
            o_imm_c         = imm_b;
            o_jump_addr_c   = i_pc + imm_b;
         end
         OPC_LOAD: begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
            writes              = 1'b1;
            o_ctrl_c.rs1        = rs1;
            o_ctrl_c.en_imm     = 1'b1;
            o_ctrl_c.mem_rd     = 1'b1;
            o_ctrl_c.mem_funct3 = funct3;
            o_imm_c             = imm_i;
         end
         OPC_STORE: begin
            legal               = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            o_ctrl_c.rs1        = rs1;
            o_ctrl_c.rs2        = rs2;
            o_ctrl_c.en_imm     = 1'b1;
            o_ctrl_c.mem_wr     = 1'b1;
            o_ctrl_c.mem_funct3 = funct3;
            o_imm_c             = imm_s;
         end
         OPC_MISC_MEM: legal = (funct3 == 3'b000);
         OPC_SYSTEM:   legal = (i_instr == INSTR_ECALL) || (i_instr == INSTR_EBREAK);
         default:      legal = 1'b0;
      endcase

      o_ctrl_c.rd    = writes ? rd : 5'd0;
      o_ctrl_c.wb_en = writes && (rd != 5'd0);

      if (!legal) begin
         o_ctrl_c         = '0;
         o_ctrl_c.illegal = 1'b1;
         o_imm_c          = '0;
         o_jump_addr_c    = '0;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake and flush.
// Define DECODE_SKID_EN to add a one-entry skid buffer and a flopped o_ready.
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ALU_OP_W = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [31:0]         i_opcode,
   input  logic [XLEN-1:0]     i_pc,
   input  logic                i_flush,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [XLEN-1:0]     o_pc,
   output logic [4:0]          o_rd,
   output logic [4:0]          o_rs1,
   output logic [4:0]          o_rs2,
   output logic                o_wb_en,
   output logic                o_en_imm,
   output logic [XLEN-1:0]     o_imm,
   output logic                o_en_jump,
   output logic [XLEN-1:0]     o_jump_addr,
   output logic [ALU_OP_W-1:0] o_alu_op,
   output logic [1:0]          o_jump,
   output logic                o_mem_rd,
   output logic                o_mem_wr,
   output logic [2:0]          o_mem_funct3,
   output logic                o_illegal_instruction
);

   typedef struct packed {
      dec_ctrl_t       ctrl;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] jump_addr;
   } entry_t;

   dec_ctrl_t       dec_ctrl_c;
   logic [XLEN-1:0] dec_imm_c;
   logic [XLEN-1:0] dec_jaddr_c;
   entry_t          dec_c;
   logic            in_fire_c;
   entry_t          out_q, out_d;
   logic            out_valid_q, out_valid_d;

   decode_comb #(.XLEN(XLEN)) u_decode_comb (
      .i_instr       (i_opcode),
      .i_pc          (i_pc),
      .o_ctrl_c      (dec_ctrl_c),
      .o_imm_c       (dec_imm_c),
      .o_jump_addr_c (dec_jaddr_c)
   );

   assign dec_c     = '{ctrl: dec_ctrl_c, pc: i_pc, imm: dec_imm_c, jump_addr: dec_jaddr_c};
   assign in_fire_c = i_valid && o_ready;

`ifdef DECODE_SKID_EN
   entry_t skid_q, skid_d;
   logic   skid_valid_q, skid_valid_d;

   assign o_ready = !skid_valid_q;

   // Output slot refills from the skid entry first; arrivals during a stall park in skid
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (i_flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || i_ready) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = in_fire_c;
            if (in_fire_c) out_d = dec_c;
         end
      end else if (in_fire_c) begin
         skid_d       = dec_c;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`else
   assign o_ready = !out_valid_q || i_ready;

   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (i_flush) begin
         out_valid_d = 1'b0;
      end else if (o_ready) begin
         out_valid_d = i_valid;
         if (i_valid) out_d = dec_c;
      end
   end
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign o_valid               = out_valid_q;
   assign o_pc                  = out_q.pc;
   assign o_rd                  = out_q.ctrl.rd;
   assign o_rs1                 = out_q.ctrl.rs1;
   assign o_rs2                 = out_q.ctrl.rs2;
   assign o_wb_en               = out_q.ctrl.wb_en;
   assign o_en_imm              = out_q.ctrl.en_imm;
   assign o_imm                 = out_q.imm;
   assign o_en_jump             = out_q.ctrl.en_jump;
   assign o_jump_addr           = out_q.jump_addr;
   assign o_alu_op              = ALU_OP_W'(out_q.ctrl.alu_op);
   assign o_jump                = out_q.ctrl.jump;
   assign o_mem_rd              = out_q.ctrl.mem_rd;
   assign o_mem_wr              = out_q.ctrl.mem_wr;
   assign o_mem_funct3          = out_q.ctrl.mem_funct3;
   assign o_illegal_instruction = out_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed RV32I vectors, a stalled/flushed
// stream, and asynchronous reset behaviour.
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        wb;
      logic        en_imm;
      logic [31:0] imm;
      logic        en_jump;
      logic [31:0] jaddr;
      logic [3:0]  alu;
      logic [1:0]  jump;
      logic        mem_rd;
      logic        mem_wr;
      logic [2:0]  f3;
      logic        ill;
   } exp_t;

   logic        i_clk = 1'b0;
   logic        i_rst, i_valid, i_flush, i_ready;
   logic [31:0] i_opcode, i_pc;
   logic        o_ready, o_valid, o_wb_en, o_en_imm, o_en_jump;
   logic        o_mem_rd, o_mem_wr, o_illegal_instruction;
   logic [31:0] o_pc, o_imm, o_jump_addr;
   logic [4:0]  o_rd, o_rs1, o_rs2;
   logic [3:0]  o_alu_op;
   logic [1:0]  o_jump;
   logic [2:0]  o_mem_funct3;

   exp_t q[$];
   exp_t exp_in;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   ready_mode = 0;

   decode_stage #(.XLEN(32), .ALU_OP_W(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_opcode(i_opcode), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
      .i_ready(i_ready), .o_pc(o_pc), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
      .o_wb_en(o_wb_en), .o_en_imm(o_en_imm), .o_imm(o_imm), .o_en_jump(o_en_jump),
      .o_jump_addr(o_jump_addr), .o_alu_op(o_alu_op), .o_jump(o_jump),
      .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_mem_funct3(o_mem_funct3),
      .o_illegal_instruction(o_illegal_instruction)
   );

   always #5 i_clk = ~i_clk;

   function automatic exp_t mk(int unsigned pc, int unsigned rd, int unsigned rs1,
                               int unsigned rs2, int unsigned wb, int unsigned ei,
                               int unsigned imm, int unsigned ej, int unsigned ja,
                               int unsigned alu, int unsigned jmp, int unsigned mr,
                               int unsigned mw, int unsigned f3);
      exp_t e;
      e.pc = 32'(pc);   e.rd = 5'(rd);     e.rs1 = 5'(rs1);   e.rs2 = 5'(rs2);
      e.wb = 1'(wb);    e.en_imm = 1'(ei); e.imm = 32'(imm);  e.en_jump = 1'(ej);
      e.jaddr = 32'(ja); e.alu = 4'(alu);  e.jump = 2'(jmp);  e.mem_rd = 1'(mr);
      e.mem_wr = 1'(mw); e.f3 = 3'(f3);    e.ill = 1'b0;
      return e;
   endfunction

   function automatic exp_t ill(logic [31:0] pc);
      exp_t e = '0;
      e.pc  = pc;
      e.ill = 1'b1;
      return e;
   endfunction

   function automatic exp_t snap();
      exp_t e;
      e.pc = o_pc;       e.rd = o_rd;         e.rs1 = o_rs1;         e.rs2 = o_rs2;
      e.wb = o_wb_en;    e.en_imm = o_en_imm; e.imm = o_imm;         e.en_jump = o_en_jump;
      e.jaddr = o_jump_addr; e.alu = o_alu_op; e.jump = o_jump;      e.mem_rd = o_mem_rd;
      e.mem_wr = o_mem_wr; e.f3 = o_mem_funct3; e.ill = o_illegal_instruction;
      return e;
   endfunction

   task automatic check(input string name, input exp_t got, input exp_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s pc=%h: got=%h required=%h", name, exp.pc, got, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%b required=%b", name, got, exp);
      end
   endtask

   // Hold one instruction on the input until accepted (bounded)
   task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                       input logic flush);
      logic acc;
      int   n = 0;
      i_valid = 1'b1; i_opcode = instr; i_pc = pc; exp_in = e; i_flush = flush;
      do begin
         @(negedge i_clk);
         acc = o_ready;
         @(posedge i_clk); #1;
         n++;
      end while (!acc && n < 100);
      if (!acc) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout pc=%h: got=not accepted required=accepted", pc);
      end
      i_valid = 1'b0; i_flush = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || o_valid) && n < 60) begin
         @(posedge i_clk); #1;
         n++;
      end
      n_cmp++;
      if (q.size() != 0 || o_valid) begin
         n_fail++;
         $display("FAIL drain: got=%0d pending required=0", q.size());
      end
   endtask

   // i_ready driver: 0 = always ready, 1 = toggle each cycle, 2 = stalled
   initial begin
      i_ready = 1'b1;
      forever begin
         @(posedge i_clk); #1;
         case (ready_mode)
            1:       i_ready = ~i_ready;
            2:       i_ready = 1'b0;
            default: i_ready = 1'b1;
         endcase
      end
   end

   // Monitor: checks outputs on each transfer out, records transfers in
   initial begin
      exp_t cur, prev, e;
      logic prev_stall = 1'b0;
      prev = '0;
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            q.delete();
            prev_stall = 1'b0;
         end else begin
            cur = snap();
            if (prev_stall) begin
               n_cmp++;
               if (!o_valid || cur !== prev) begin
                  n_fail++;
                  $display("FAIL hold: got=%h required=%h", cur, prev);
               end
            end
`ifndef DECODE_SKID_EN
            check_bit("o_ready_comb", o_ready, !o_valid || i_ready);
`endif
            if (i_flush) begin
               q.delete();
            end else begin
               if (o_valid && i_ready) begin
                  if (q.size() == 0) begin
                     n_cmp++; n_fail++;
                     $display("FAIL unexpected_output pc=%h: got=valid required=none", o_pc);
                  end else begin
                     e = q.pop_front();
                     check("decode", cur, e);
                  end
               end
               if (i_valid && o_ready) q.push_back(exp_in);
            end
            prev_stall = o_valid && !i_ready && !i_flush;
            prev = cur;
         end
      end
   end

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_opcode = '0; i_pc = '0;
      exp_in = '0;
      repeat (2) @(posedge i_clk);
      #1;
      check("reset_outputs", snap(), '0);
      check_bit("reset_valid", o_valid, 1'b0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      check_bit("ready_after_reset", o_ready, 1'b1);

      // Directed decode vectors, execute always ready
      send(32'h002081B3, 32'h100, mk(32'h100, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      send(32'h008000EF, 32'h200, mk(32'h200, 1, 0, 0, 1, 1, 32'h204, 0, 32'h208, 0, 1, 0, 0, 0), 1'b0);
      send(32'h0020A063, 32'h300, ill(32'h300), 1'b0);
      send(32'hFFC12283, 32'h400, mk(32'h400, 5, 2, 0, 1, 1, 32'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 2), 1'b0);
      send(32'h40628233, 32'h104, mk(32'h104, 4, 5, 6, 1, 0, 0, 0, 0, 8, 0, 0, 0, 0), 1'b0);
      send(32'h40629233, 32'h108, ill(32'h108), 1'b0);
      send(32'h40345393, 32'h10C, mk(32'h10C, 7, 8, 0, 1, 1, 3, 0, 0, 13, 0, 0, 0, 0), 1'b0);
      send(32'h00000013, 32'h110, mk(32'h110, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      send(32'hFFF08093, 32'h114, mk(32'h114, 1, 1, 0, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      send(32'h0051B113, 32'h118, mk(32'h118, 2, 3, 0, 1, 1, 5, 0, 0, 3, 0, 0, 0, 0), 1'b0);
      send(32'h12345537, 32'h11C, mk(32'h11C, 10, 0, 0, 1, 1, 32'h12345000, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      send(32'h80000597, 32'h1000, mk(32'h1000, 11, 0, 0, 1, 1, 32'h80000000, 1, 32'h1000, 0, 0, 0, 0, 0), 1'b0);
      send(32'h004280E7, 32'h500, mk(32'h500, 1, 5, 0, 1, 1, 4, 0, 32'h504, 0, 2, 0, 0, 0), 1'b0);
      send(32'h004290E7, 32'h504, ill(32'h504), 1'b0);
      send(32'hFE209EE3, 32'h600, mk(32'h600, 0, 1, 2, 0, 0, 32'hFFFFFFFC, 0, 32'h5FC, 9, 3, 0, 0, 0), 1'b0);
      send(32'h00612423, 32'h700, mk(32'h700, 0, 2, 6, 0, 1, 8, 0, 0, 0, 0, 0, 1, 2), 1'b0);
      send(32'h00613423, 32'h704, ill(32'h704), 1'b0);
      send(32'h0000C483, 32'h708, mk(32'h708, 9, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 4), 1'b0);
      send(32'h0000B483, 32'h70C, ill(32'h70C), 1'b0);
      send(32'h0FF0000F, 32'h710, mk(32'h710, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      send(32'h00000073, 32'h714, mk(32'h714, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      send(32'h00100073, 32'h718, mk(32'h718, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      send(32'h30529073, 32'h71C, ill(32'h71C), 1'b0);
      send(32'h00000000, 32'h720, ill(32'h720), 1'b0);
      send(32'hFFFFFFFF, 32'h724, ill(32'h724), 1'b0);
      send(32'h0080006F, 32'hFFFFFFFC, mk(32'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 0, 4, 0, 1, 0, 0, 0), 1'b0);
      send(32'h00208033, 32'h728, mk(32'h728, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      send(32'h403150B3, 32'h72C, mk(32'h72C, 1, 2, 3, 1, 0, 0, 0, 0, 13, 0, 0, 0, 0), 1'b0);
      send(32'h40001093, 32'h730, ill(32'h730), 1'b0);
      drain();

      // Back-to-back stream of addi xk,x0,k with i_ready toggling and one flush
      ready_mode = 1;
      for (int k = 1; k <= 14; k++) begin
         logic [31:0] ins;
         logic [31:0] pc;
         ins = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
         pc  = 32'h2000 + 32'(k * 4);
         send(ins, pc, mk(pc, k, 0, 0, 1, 1, k, 0, 0, 0, 0, 0, 0, 0), k == 7);
      end
      drain();

      // Stall one instruction at the output, then reset asynchronously
      ready_mode = 2;
      send(32'h002081B3, 32'h900, mk(32'h900, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      @(posedge i_clk); #1;
      check_bit("stalled_valid", o_valid, 1'b1);
      #2 i_rst = 1'b1;
      #1;
      check("async_reset_outputs", snap(), '0);
      check_bit("async_reset_valid", o_valid, 1'b0);
      ready_mode = 0;
      @(posedge i_clk); @(posedge i_clk); #1;
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      check_bit("ready_after_midstream_reset", o_ready, 1'b1);
      check_bit("valid_after_midstream_reset", o_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
